uart_tx_buffered: RTL and testbench

//  Buffered UART transmitter: 8N1 serialiser fronted by a synchronous byte FIFO.

---
 rtl/uart_tx_buffered.sv | 159 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a synchronous byte FIFO with a valid/ready push
// port, drained back-to-back by a serialiser that drives o_Tx_Serial (idle high).
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3
) (
  input  logic               i_Clock,
  input  logic               i_Rst_L,
  input  logic               i_Tx_DV,
  input  logic [7:0]         i_Tx_Byte,
  output logic               o_Tx_Ready,
  output logic               o_Tx_Serial,
  output logic               o_Tx_Active,
  output logic               o_Tx_Done,
  output logic               o_Overflow,
  output logic [FIFO_AW:0]   o_Fifo_Count
);

  localparam int                 CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   DEPTH    = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               push, pop, fifo_empty, overflow;

  // Serialiser state
  state_t             state, state_next;
  logic [CNT_W-1:0]   clk_cnt, clk_cnt_next;
  logic [2:0]         bit_idx, bit_idx_next;
  logic [7:0]         shift, shift_next;
  logic               serial, serial_next;
  logic               active, active_next;
  logic               done, done_next;

  assign o_Tx_Ready = (count != DEPTH);
  assign fifo_empty = (count == '0);
  // A full FIFO refuses the write even when a pop frees a slot on the same edge.
  assign push       = i_Tx_DV && o_Tx_Ready;

  // NOTE: the storage array carries no reset; only pointers and count define its contents.
  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= i_Tx_Byte;
  end

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow <= i_Tx_DV && !o_Tx_Ready;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      serial  <= 1'b1;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      serial  <= serial_next;
      active  <= active_next;
      done    <= done_next;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    serial_next  = serial;
    active_next  = active;
    done_next    = 1'b0;
    pop          = 1'b0;

    case (state)
      S_IDLE: begin
        serial_next = 1'b1;
        if (!fifo_empty) begin
          pop          = 1'b1;
          shift_next   = mem[rd_ptr];
          serial_next  = 1'b0;
          active_next  = 1'b1;
          clk_cnt_next = '0;
          state_next   = S_START;
        end
      end
      S_START: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          serial_next  = shift[0];
          state_next   = S_DATA;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            serial_next = 1'b1;
            state_next  = S_STOP;
          end else begin
            // Shift right so the next data bit is always at position 1 before the move.
            bit_idx_next = bit_idx + 1'b1;
            shift_next   = {1'b0, shift[7:1]};
            serial_next  = shift[1];
          end
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_next = '0;
          done_next    = 1'b1;
          active_next  = 1'b0;
          state_next   = S_IDLE;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign o_Tx_Serial  = serial;
  assign o_Tx_Active  = active;
  assign o_Tx_Done    = done;
  assign o_Overflow   = overflow;
  assign o_Fifo_Count = count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: one instance at 87 clocks/bit, one at 4 clocks/bit,
// each watched by a mid-bit sampling receiver model.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  logic       rst_n_a = 1'b0, dv_a = 1'b0;
  logic [7:0] byte_a = '0;
  logic       ready_a, ser_a, active_a, done_a, ovf_a;
  logic [3:0] count_a;

  logic       rst_n_b = 1'b0, dv_b = 1'b0;
  logic [7:0] byte_b = '0;
  logic       ready_b, ser_b, active_b, done_b, ovf_b;
  logic [3:0] count_b;

  logic       ser_line [2];
  logic       rst_line [2];
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  int         t_a [$];
  int         t_b [$];
  int         done_t_b [$];
  logic [9:0] bits_a = '0;
  int         done_cnt_b = 0;
  int         ovf_cnt_b = 0;

  uart_tx_buffered #(.CLKS_PER_BIT(87), .FIFO_DEPTH(8), .FIFO_AW(3)) u_dut_a (
    .i_Clock(clk), .i_Rst_L(rst_n_a), .i_Tx_DV(dv_a), .i_Tx_Byte(byte_a),
    .o_Tx_Ready(ready_a), .o_Tx_Serial(ser_a), .o_Tx_Active(active_a),
    .o_Tx_Done(done_a), .o_Overflow(ovf_a), .o_Fifo_Count(count_a)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .FIFO_AW(3)) u_dut_b (
    .i_Clock(clk), .i_Rst_L(rst_n_b), .i_Tx_DV(dv_b), .i_Tx_Byte(byte_b),
    .o_Tx_Ready(ready_b), .o_Tx_Serial(ser_b), .o_Tx_Active(active_b),
    .o_Tx_Done(done_b), .o_Overflow(ovf_b), .o_Fifo_Count(count_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign ser_line[0] = ser_a;
  assign ser_line[1] = ser_b;
  assign rst_line[0] = rst_n_a;
  assign rst_line[1] = rst_n_b;

  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      done_cnt_b++;
      done_t_b.push_back(cyc);
    end
    if (ovf_b === 1'b1) ovf_cnt_b++;
  end

  // Receiver model: detects the start bit, samples each bit at its centre, drops frames cut by reset.
  task automatic rx_monitor(input int which, input int cpb);
    logic [9:0] bits;
    int         t0;
    bit         abort;
    forever begin
      @(negedge clk);
      if (rst_line[which] === 1'b1 && ser_line[which] === 1'b0) begin
        t0    = cyc;
        abort = 1'b0;
        bits  = '0;
        for (int b = 0; b < 10 && !abort; b++) begin
          for (int k = 0; k < ((b == 0) ? cpb / 2 : cpb); k++) begin
            @(negedge clk);
            if (rst_line[which] !== 1'b1) abort = 1'b1;
          end
          bits[b] = ser_line[which];
        end
        if (!abort) begin
          if (which == 0) begin
            q_a.push_back(bits[8:1]);
            t_a.push_back(t0);
            bits_a = bits;
          end else begin
            q_b.push_back(bits[8:1]);
            t_b.push_back(t0);
          end
        end
      end
    end
  endtask

  initial rx_monitor(0, 87);
  initial rx_monitor(1, 4);

  task automatic wait_rx(input int which, input int n, input int budget);
    int g = 0;
    while (((which == 0) ? q_a.size() : q_b.size()) < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (g >= budget) begin
      n_fail++;
      $display("FAIL rx_timeout[%0d]: got %0d frames, required %0d", which,
               (which == 0) ? q_a.size() : q_b.size(), n);
    end
  endtask

  task automatic test_reset;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (ser_a !== 1'b1)    begin n_fail++; $display("FAIL reset_serial: got %b required 1", ser_a); end
    n_checks++; if (active_a !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b required 0", active_a); end
    n_checks++; if (done_a !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b required 0", done_a); end
    n_checks++; if (ovf_a !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow: got %b required 0", ovf_a); end
    n_checks++; if (count_a !== 4'd0)  begin n_fail++; $display("FAIL reset_count: got %0d required 0", count_a); end
    n_checks++; if (ready_a !== 1'b1)  begin n_fail++; $display("FAIL reset_ready: got %b required 1", ready_a); end
    n_checks++; if (ser_b !== 1'b1)    begin n_fail++; $display("FAIL reset_serial_b: got %b required 1", ser_b); end
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (ser_a !== 1'b1)    begin n_fail++; $display("FAIL post_reset_idle: got %b required 1", ser_a); end
  endtask

  task automatic test_single_frame;
    int base = q_a.size();
    int ts, g;
    @(negedge clk); dv_a = 1'b1; byte_a = 8'hAB;
    @(negedge clk); dv_a = 1'b0;
    n_checks++; if (ser_a !== 1'b1)   begin n_fail++; $display("FAIL sf_line_at_accept: got %b required 1", ser_a); end
    n_checks++; if (count_a !== 4'd1) begin n_fail++; $display("FAIL sf_count_at_accept: got %0d required 1", count_a); end
    @(negedge clk);
    ts = cyc;
    n_checks++; if (ser_a !== 1'b0)    begin n_fail++; $display("FAIL sf_start_low: got %b required 0", ser_a); end
    n_checks++; if (active_a !== 1'b1) begin n_fail++; $display("FAIL sf_active: got %b required 1", active_a); end
    n_checks++; if (count_a !== 4'd0)  begin n_fail++; $display("FAIL sf_count_popped: got %0d required 0", count_a); end
    g = 0;
    while (done_a !== 1'b1 && g < 1000) begin @(negedge clk); g++; end
    n_checks++; if (cyc - ts !== 870)  begin n_fail++; $display("FAIL sf_done_latency: got %0d required 870", cyc - ts); end
    n_checks++; if (active_a !== 1'b0) begin n_fail++; $display("FAIL sf_active_at_done: got %b required 0", active_a); end
    @(negedge clk);
    n_checks++; if (done_a !== 1'b0)   begin n_fail++; $display("FAIL sf_done_width: got %b required 0", done_a); end
    wait_rx(0, base + 1, 200);
    n_checks++; if (q_a[base] !== 8'hAB) begin n_fail++; $display("FAIL sf_rx_byte: got %h required ab", q_a[base]); end
    n_checks++; if (bits_a !== 10'b1101010110) begin n_fail++; $display("FAIL sf_mid_bits: got %b required 1101010110", bits_a); end
  endtask

  task automatic test_overflow;
    int   base = q_a.size();
    logic [3:0] exp_count;
    @(negedge clk); dv_a = 1'b1; byte_a = 8'h30;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp_count = (i == 0) ? 4'd1 : ((i < 9) ? 4'(i) : 4'd8);
      n_checks++; if (count_a !== exp_count) begin n_fail++; $display("FAIL ov_count[%0d]: got %0d required %0d", i, count_a, exp_count); end
      n_checks++; if (ready_a !== (i < 8))   begin n_fail++; $display("FAIL ov_ready[%0d]: got %b required %b", i, ready_a, (i < 8)); end
      n_checks++; if (ovf_a !== (i == 9))    begin n_fail++; $display("FAIL ov_pulse[%0d]: got %b required %b", i, ovf_a, (i == 9)); end
      if (i < 9) byte_a = 8'h31 + 8'(i);
      else       dv_a = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL ov_pulse_width: got %b required 0", ovf_a); end
    wait_rx(0, base + 9, 9 * 871 + 500);
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (q_a[base+i] !== 8'h30 + 8'(i)) begin n_fail++; $display("FAIL ov_rx[%0d]: got %h required %h", i, q_a[base+i], 8'h30 + 8'(i)); end
      if (i > 0) begin
        n_checks++; if (t_a[base+i] - t_a[base+i-1] !== 871) begin n_fail++; $display("FAIL ov_spacing[%0d]: got %0d required 871", i, t_a[base+i] - t_a[base+i-1]); end
      end
    end
    repeat (900) @(negedge clk);
    n_checks++; if (q_a.size() !== base + 9) begin n_fail++; $display("FAIL ov_dropped: got %0d frames required %0d", q_a.size() - base, 9); end
  endtask

  task automatic test_fast_bytes;
    int         base = q_b.size();
    int         dbase = done_t_b.size();
    logic [7:0] vec [4] = '{8'h00, 8'hFF, 8'h55, 8'h32};
    @(negedge clk); dv_b = 1'b1; byte_b = vec[0];
    for (int i = 1; i < 4; i++) begin @(negedge clk); byte_b = vec[i]; end
    @(negedge clk); dv_b = 1'b0;
    wait_rx(1, base + 4, 400);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (q_b[base+i] !== vec[i]) begin n_fail++; $display("FAIL fb_rx[%0d]: got %h required %h", i, q_b[base+i], vec[i]); end
      n_checks++; if (done_t_b[dbase+i] - t_b[base+i] !== 40) begin n_fail++; $display("FAIL fb_frame_len[%0d]: got %0d required 40", i, done_t_b[dbase+i] - t_b[base+i]); end
    end
  endtask

  task automatic test_push_pop;
    int         base = q_b.size();
    int         g = 0;
    logic [7:0] vec [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    @(negedge clk); dv_b = 1'b1; byte_b = vec[0];
    for (int i = 1; i < 4; i++) begin @(negedge clk); byte_b = vec[i]; end
    @(negedge clk); dv_b = 1'b0;
    n_checks++; if (count_b !== 4'd3) begin n_fail++; $display("FAIL pp_count_before: got %0d required 3", count_b); end
    while (done_b !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    n_checks++; if (g >= 100) begin n_fail++; $display("FAIL pp_done_timeout: waited %0d cycles", g); end
    dv_b = 1'b1; byte_b = vec[4];
    @(negedge clk); dv_b = 1'b0;
    n_checks++; if (count_b !== 4'd3) begin n_fail++; $display("FAIL pp_count_after: got %0d required 3", count_b); end
    n_checks++; if (ovf_b !== 1'b0)   begin n_fail++; $display("FAIL pp_overflow: got %b required 0", ovf_b); end
    wait_rx(1, base + 5, 400);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (q_b[base+i] !== vec[i]) begin n_fail++; $display("FAIL pp_rx[%0d]: got %h required %h", i, q_b[base+i], vec[i]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    int base = q_b.size();
    int dsnap;
    bit idle_ok = 1'b1;
    @(negedge clk); dv_b = 1'b1; byte_b = 8'hAB;
    @(negedge clk); byte_b = 8'h01;
    @(negedge clk); byte_b = 8'h02;
    @(negedge clk); dv_b = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (count_b !== 4'd2) begin n_fail++; $display("FAIL rm_count_queued: got %0d required 2", count_b); end
    n_checks++; if (ser_b !== 1'b0)   begin n_fail++; $display("FAIL rm_bit4: got %b required 0", ser_b); end
    dsnap = done_cnt_b;
    #1 rst_n_b = 1'b0;
    #1;
    n_checks++; if (ser_b !== 1'b1)    begin n_fail++; $display("FAIL rm_async_line: got %b required 1", ser_b); end
    n_checks++; if (count_b !== 4'd0)  begin n_fail++; $display("FAIL rm_flush: got %0d required 0", count_b); end
    n_checks++; if (active_b !== 1'b0) begin n_fail++; $display("FAIL rm_active: got %b required 0", active_b); end
    repeat (3) @(negedge clk);
    rst_n_b = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (ser_b !== 1'b1 || count_b !== 4'd0) idle_ok = 1'b0;
    end
    n_checks++; if (!idle_ok) begin n_fail++; $display("FAIL rm_idle_after: got activity required idle line"); end
    n_checks++; if (done_cnt_b !== dsnap) begin n_fail++; $display("FAIL rm_no_done: got %0d pulses required 0", done_cnt_b - dsnap); end
    @(negedge clk); dv_b = 1'b1; byte_b = 8'h5A;
    @(negedge clk); dv_b = 1'b0;
    wait_rx(1, base + 1, 200);
    repeat (60) @(negedge clk);
    n_checks++; if (q_b.size() !== base + 1) begin n_fail++; $display("FAIL rm_frames: got %0d required 1", q_b.size() - base); end
    n_checks++; if (q_b[base] !== 8'h5A)     begin n_fail++; $display("FAIL rm_new_byte: got %h required 5a", q_b[base]); end
  endtask

  task automatic test_fifo_wrap;
    int base = q_b.size();
    int osnap = ovf_cnt_b;
    int g;
    for (int i = 0; i < 20; i++) begin
      g = 0;
      while (ready_b !== 1'b1 && g < 200) begin @(negedge clk); g++; end
      if (g >= 200) begin n_checks++; n_fail++; $display("FAIL fw_ready_timeout[%0d]: ready stuck low", i); end
      @(negedge clk); dv_b = 1'b1; byte_b = 8'(i * 7 + 3);
      @(negedge clk); dv_b = 1'b0;
      repeat (3) @(negedge clk);
    end
    wait_rx(1, base + 20, 1500);
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (q_b[base+i] !== 8'(i * 7 + 3)) begin n_fail++; $display("FAIL fw_rx[%0d]: got %h required %h", i, q_b[base+i], 8'(i * 7 + 3)); end
    end
    n_checks++; if (ovf_cnt_b !== osnap) begin n_fail++; $display("FAIL fw_overflow: got %0d pulses required 0", ovf_cnt_b - osnap); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_fast_bytes();
    test_push_pop();
    test_reset_mid_frame();
    test_fifo_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
